// File: rtl/vcache_stat_dump_sequencer.sv
// Expands one tagged dump request into a sequence of print_stat_v pulses, one per enabled
// vcache in ascending index order, separated by a fixed idle gap. Also provides the shared
// free-running global counter used by every profiler.
module vcache_stat_dump_sequencer #(
  parameter int unsigned num_cache_p  = 4,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned gap_cycles_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    req_v_i,
  input  logic [data_width_p-1:0] req_tag_i,
  input  logic [num_cache_p-1:0]  req_mask_i,
  output logic                    req_ready_o,
  output logic [num_cache_p-1:0]  print_stat_v_o,
  output logic [data_width_p-1:0] print_stat_tag_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [31:0]             global_ctr_o
);

  localparam int unsigned gap_width_lp = (gap_cycles_p > 0) ? $clog2(gap_cycles_p + 1) : 1;
  localparam logic [gap_width_lp-1:0] gap_init_lp =
    gap_width_lp'((gap_cycles_p > 0) ? (gap_cycles_p - 1) : 0);

  typedef enum logic [1:0] {StIdle, StIssue, StGap, StDone} state_e;

  state_e                  state;
  logic [num_cache_p-1:0]  pending_r;
  logic [gap_width_lp-1:0] gap_cnt_r;
  logic [num_cache_p-1:0]  remaining;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [num_cache_p-1:0] lowest_one(input logic [num_cache_p-1:0] v);
    return v & (-v);
  endfunction

  // Bits still to be dumped once the current ISSUE cycle retires its bit.
  always_comb begin
    remaining = pending_r & ~lowest_one(pending_r);
  end

  // Dump sequencer; every output is a register loaded with its value for the next cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state            <= StIdle;
      pending_r        <= '0;
      gap_cnt_r        <= '0;
      req_ready_o      <= 1'b1;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      print_stat_v_o   <= '0;
      print_stat_tag_o <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_v_i) begin
            print_stat_tag_o <= req_tag_i;
            pending_r        <= req_mask_i;
            req_ready_o      <= 1'b0;
            busy_o           <= 1'b1;
            if (req_mask_i == '0) begin
              state  <= StDone;
              done_o <= 1'b1;
            end else begin
              state          <= StIssue;
              print_stat_v_o <= lowest_one(req_mask_i);
            end
          end
        end
        StIssue: begin
          pending_r <= remaining;
          if (remaining == '0) begin
            state          <= StDone;
            done_o         <= 1'b1;
            print_stat_v_o <= '0;
          end else if (gap_cycles_p == 0) begin
            print_stat_v_o <= lowest_one(remaining);
          end else begin
            state          <= StGap;
            gap_cnt_r      <= gap_init_lp;
            print_stat_v_o <= '0;
          end
        end
        StGap: begin
          if (gap_cnt_r == '0) begin
            state          <= StIssue;
            print_stat_v_o <= lowest_one(pending_r);
          end else begin
            gap_cnt_r <= gap_cnt_r - 1'b1;
          end
        end
        StDone: begin
          state       <= StIdle;
          done_o      <= 1'b0;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Free-running cycle counter shared by all profilers; wraps naturally.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      global_ctr_o <= '0;
    end else begin
      global_ctr_o <= global_ctr_o + 32'd1;
    end
  end

endmodule

// File: doc/vcache_stat_dump_sequencer.md
# vcache_stat_dump_sequencer

Sequences statistics dumps across the vcache profilers of a manycore testbench. A single dump request, carrying a tag, is expanded into one `print_stat_v` pulse per enabled vcache, issued one cache at a time in ascending index order with a fixed idle gap between pulses. The gap keeps profiler log appends from colliding within a cycle. The block also supplies the shared free-running `global_ctr` consumed by every profiler.

## Interface
- `num_cache_p`, 4: number of vcache profilers driven; must be ≥1.
- `data_width_p`, 32: width of the tag.
- `gap_cycles_p`, 2: idle cycles between consecutive pulses; may be 0.
- `clk_i`  in  1  clock; all state updates on posedge.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `req_v_i`  in  1  dump request valid.
- `req_tag_i`  in  data_width_p  tag for this dump.
- `req_mask_i`  in  num_cache_p  bit i set means dump vcache i.
- `req_ready_o`  out  1  high only in IDLE; request accepted on posedge when `req_v_i & req_ready_o`.
- `print_stat_v_o`  out  num_cache_p  one-hot or zero; bit i drives vcache i `print_stat_v_i`.
- `print_stat_tag_o`  out  data_width_p  latched tag; drives all profilers' `print_stat_tag_i`.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle pulse when a dump completes.
- `global_ctr_o`  out  32  free-running cycle counter.

## Operation
- There are four states: IDLE, ISSUE, GAP and DONE. All outputs come from registers or state decode only; there is no combinational input-to-output path.
- **IDLE:** `req_ready_o`=1. On accept:
  - latch `req_tag_i` into `print_stat_tag_o`;
  - latch `req_mask_i` into `pending_r`;
  - go to DONE if the mask is 0, otherwise go to ISSUE.
- **ISSUE:** exactly one cycle.
  - `print_stat_v_o` = one-hot of the lowest set bit of `pending_r`; that bit is cleared at the cycle end.
  - If the remaining `pending_r` is 0, go to DONE.
  - Otherwise, if `gap_cycles_p`=0, stay in ISSUE for the next bit.
  - Otherwise go to GAP with `gap_cnt_r` = `gap_cycles_p`-1.
- **GAP:**
  - `print_stat_v_o`=0.
  - If `gap_cnt_r`=0, go to ISSUE; otherwise decrement it.
  - GAP therefore lasts exactly `gap_cycles_p` cycles.
- **DONE:** `done_o`=1 for one cycle, then go to IDLE.
- **Tag hold:** `print_stat_tag_o` holds its value after the dump until the next accept.
- **Requests while busy:** `req_v_i` is ignored while busy. No queuing and no error is raised; the requester must hold its request until `req_ready_o` is high.
- **`global_ctr_o`:** increments by 1 every cycle, wraps from 0xFFFF_FFFF to 0, and is independent of the FSM.
- **Gap counter width:** `$clog2(gap_cycles_p+1)`, minimum 1 bit.

## Timing
- **Reset values:**
  - State = IDLE, so `req_ready_o`=1 and `busy_o`=0.
  - `print_stat_v_o`=0, `print_stat_tag_o`=0, `done_o`=0, `global_ctr_o`=0, `pending_r`=0.
- **Pulse timing:** with accept at posedge of cycle 0, pulse k (0-based) is high during cycle 1+k·(`gap_cycles_p`+1).
- **Completion timing:** `done_o` is high in the cycle after the last pulse, and `req_ready_o` rises the cycle after that.
  - With an empty mask, `done_o` is high in cycle 1 and ready returns in cycle 2.
- **Back-to-back dumps:** the minimum spacing between accepted requests is m·(G+1)−G+2 cycles, where m = popcount(mask) ≥1 and G = `gap_cycles_p`.
- **Profiler sampling:** profilers sample on negedge. Registered posedge outputs are stable at that sample, and each pulse is seen by exactly one negedge.
- **Reset mid-operation:**
  - Asserting `reset_n_i` forces all outputs to their reset values immediately, without waiting for a clock edge.
  - The dump in progress is discarded and not resumed.
  - The first accept is possible on the first posedge after deassertion.

## Test plan
1. **Full mask, default gap.** `num_cache_p`=4, G=2; accept mask 4'b1111, tag 0x5 at cycle 0 → `print_stat_v_o` = 0001 at cycle 1, 0010 at 4, 0100 at 7, 1000 at 10, zero elsewhere; tag 0x5 throughout; `done_o` at 11; `req_ready_o` high again at 12.
2. **Sparse mask.** Mask 4'b1010, tag 0xA → pulses 0010 at 1 and 1000 at 4; `done_o` at 5; no other bits ever set.
3. **Empty mask.** Mask 0, tag 0x7 → no pulses; `done_o` at 1; ready at 2; `print_stat_tag_o`=0x7 from cycle 1.
4. **Busy request and no gap.** G=0, mask 4'b0111; hold `req_v_i` with tag 0x1 throughout → pulses 0001, 0010, 0100 at cycles 1, 2, 3; `done_o` at 4; the second accept happens at cycle 5 and is the only other accept.
5. **Reset mid-gap.** Mask 4'b1111; assert `reset_n_i` low at cycle 5 (GAP) → all outputs reset within the same cycle; `global_ctr_o`=0; after release no pulse occurs until a new accept, and the new dump starts again from vcache 0.
6. **Counter check.** `global_ctr_o` equals the number of posedges since reset release, including across a completed dump.
